// File: rtl/mul16_seq_pkg.sv
// mul16_seq_pkg
// Shared constants for the 16x16 sequencer built around an external 8x8 core.
//   - FSM state encodings (IDLE / RUN / DONE)
//   - number of partial-product passes
//   - per-pass operand-half selects and accumulator shift amounts
package mul16_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int NUM_PASSES = 4;

    // Pass order: aL*bL, aH*bL, aL*bH, aH*bH. Bit n set = use the high byte in pass n.
    localparam logic [NUM_PASSES-1:0] A_HI_SEL = 4'b1010;
    localparam logic [NUM_PASSES-1:0] B_HI_SEL = 4'b1100;

    // Left shift applied to each pass's partial product before accumulation.
    function automatic logic [4:0] pass_shift(input logic [1:0] pass);
        logic [4:0] sh;
        case (pass)
            2'd0:    sh = 5'd0;
            2'd1:    sh = 5'd8;
            2'd2:    sh = 5'd8;
            default: sh = 5'd16;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul16_pass_acc.sv
// mul16_pass_acc
// 32-bit shift-and-add accumulator for the partial products of one 16x16 multiply.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         zero the accumulator (start of a new product; wins over en)
//   en          add the current partial product at this edge
//   pass        pass index 0..3, selects the shift amount
//   part        16-bit partial product from the 8x8 core
//   acc         accumulated value
module mul16_pass_acc
    import mul16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  pass,
    input  logic [15:0] part,
    output logic [31:0] acc
);

    logic [31:0] acc_d;
    logic [31:0] acc_q;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            // The final sum of four shifted 16-bit terms fits in 32 bits, so no carry-out is kept.
            acc_d = acc_q + (32'(part) << pass_shift(pass));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mul16_sequencer.sv
// mul16_sequencer
// 16x16 unsigned multiplier that time-multiplexes one combinational 8x8 core over
// four passes, holding each operand pair for SETTLE_CYCLES before sampling core_p.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b   operand handshake (accepted only in IDLE)
//   out_valid/out_ready/out_p     product handshake (held stable under backpressure)
//   core_x/core_y                 registered operands to the 8x8 core
//   core_p                        core result (bit 16 is never set by an 8x8 core)
//   busy                          high whenever not IDLE
module mul16_sequencer
    import mul16_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic [7:0]  core_x,
    output logic [7:0]  core_y,
    input  logic [16:0] core_p,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       PASS_LAST = 3'(NUM_PASSES - 1);
    localparam logic [2:0]       PASS_WB   = 3'(NUM_PASSES);

    state_t            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [2:0]        pass_d, pass_q;
    logic [2:0]        pass_inc;
    logic [15:0]       a_d, a_q;
    logic [15:0]       b_d, b_q;
    logic [7:0]        core_x_d, core_x_q;
    logic [7:0]        core_y_d, core_y_q;
    logic [31:0]       out_p_d, out_p_q;
    logic              acc_clr;
    logic              acc_en;
    logic [31:0]       acc;
    logic              core_p_unused;

    assign core_p_unused = core_p[16];
    assign pass_inc      = pass_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        a_d      = a_q;
        b_d      = b_q;
        core_x_d = core_x_q;
        core_y_d = core_y_q;
        out_p_d  = out_p_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    acc_clr  = 1'b1;
                    pass_d   = '0;
                    cnt_d    = '0;
                    core_x_d = in_a[7:0];
                    core_y_d = in_b[7:0];
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (pass_q == PASS_WB) begin
                    // Extra cycle after the last add so out_p captures the settled accumulator.
                    out_p_d = acc;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    acc_en = 1'b1;
                    pass_d = pass_inc;
                    cnt_d  = '0;
                    if (pass_q != PASS_LAST) begin
                        core_x_d = A_HI_SEL[pass_inc[1:0]] ? a_q[15:8] : a_q[7:0];
                        core_y_d = B_HI_SEL[pass_inc[1:0]] ? b_q[15:8] : b_q[7:0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register, including the operand latches, is reset so an aborted product leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pass_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            core_x_q <= '0;
            core_y_q <= '0;
            out_p_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            a_q      <= a_d;
            b_q      <= b_d;
            core_x_q <= core_x_d;
            core_y_q <= core_y_d;
            out_p_q  <= out_p_d;
        end
    end

    mul16_pass_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .pass  (pass_q[1:0]),
        .part  (core_p[15:0]),
        .acc   (acc)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_p     = out_p_q;
    assign core_x    = core_x_q;
    assign core_y    = core_y_q;

endmodule

// File: tb/tb_mul16_sequencer.sv
// tb_mul16_sequencer
// Two sequencer instances: index 0 with SETTLE_CYCLES=1, index 1 with SETTLE_CYCLES=3.
// Each drives a behavioural 8x8 core that returns X until its operands have been
// stable long enough. Expected products are queued at issue time and a monitor
// compares them whenever a product handshake occurs.
module tb_mul16_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_a      [2];
    logic [15:0] in_b      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_p     [2];
    logic [7:0]  core_x    [2];
    logic [7:0]  core_y    [2];
    logic [16:0] core_p    [2];
    logic        busy      [2];

    typedef struct {
        int          inst;
        logic [31:0] p;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] seen_xy [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : 3;
        logic [7:0] last_x = 8'h00;
        logic [7:0] last_y = 8'h00;
        int         age    = 0;

        mul16_sequencer #(.SETTLE_CYCLES(S), .CNT_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_a      (in_a[g]),
            .in_b      (in_b[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_p     (out_p[g]),
            .core_x    (core_x[g]),
            .core_y    (core_y[g]),
            .core_p    (core_p[g]),
            .busy      (busy[g])
        );

        // Core model: result becomes valid only once the operands have been held
        // for the full settle window ending at the sampling edge.
        always @(posedge clk) begin
            #1;
            if (core_x[g] !== last_x || core_y[g] !== last_y) begin
                last_x = core_x[g];
                last_y = core_y[g];
                age    = 0;
            end else if (age < 1000) begin
                age++;
            end
        end

        assign core_p[g] = (age >= S - 1) ? {1'b0, {8'h00, last_x} * {8'h00, last_y}} : 17'bx;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard monitor: sample away from the rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n && out_valid[i] && out_ready[i]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {31'b0, out_valid[i]}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("product_inst", i, e.inst);
                    check("product", out_p[i], e.p);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic start_op(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] p, input bit push);
        exp_t e;
        check("in_ready_before_accept", {31'b0, in_ready[i]}, 32'd1);
        in_valid[i] = 1'b1;
        in_a[i]     = a;
        in_b[i]     = b;
        if (push) begin
            e.inst = i;
            e.p    = p;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    // Counts cycles from the accept edge until out_valid is seen; records the
    // first four operand pairs and whether in_ready stayed low throughout.
    task automatic wait_valid(input int i, output int lat, output bit rdy_low);
        lat     = 0;
        rdy_low = 1'b1;
        while (!out_valid[i] && lat < 60) begin
            if (lat < 4) seen_xy[lat] = {core_x[i], core_y[i]};
            if (in_ready[i]) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready[i]) rdy_low = 1'b0;
        check("out_valid_within_budget", {31'b0, out_valid[i]}, 32'd1);
    endtask

    initial begin
        int lat;
        bit rdy_low;
        bit saw_valid;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_a[i]      = '0;
            in_b[i]      = '0;
            out_ready[i] = 1'b1;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'b0, in_ready[0]},  32'd1);
        check("reset_out_valid", {31'b0, out_valid[0]}, 32'd0);
        check("reset_out_p",     out_p[0],              32'd0);
        check("reset_core_xy",   {16'b0, core_x[0], core_y[0]}, 32'd0);
        check("reset_busy",      {31'b0, busy[0]},      32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic product, latency and operand sequence.
        start_op(0, 16'h1234, 16'h5678, 32'h0626_0060, 1'b1);
        wait_valid(0, lat, rdy_low);
        check("latency_s1", lat, 32'd5);
        check("core_xy_pass0", {16'b0, seen_xy[0]}, 32'h3478);
        check("core_xy_pass1", {16'b0, seen_xy[1]}, 32'h1278);
        check("core_xy_pass2", {16'b0, seen_xy[2]}, 32'h3456);
        check("core_xy_pass3", {16'b0, seen_xy[3]}, 32'h1256);
        check("core_xy_hold_done", {16'b0, core_x[0], core_y[0]}, 32'h1256);
        @(posedge clk);
        #1;

        // Maximum operands.
        start_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
        wait_valid(0, lat, rdy_low);
        @(posedge clk);
        #1;

        // Zero operand still takes full latency.
        start_op(0, 16'h0000, 16'hABCD, 32'h0000_0000, 1'b1);
        wait_valid(0, lat, rdy_low);
        check("latency_zero", lat, 32'd5);
        check("in_ready_low_while_busy", {31'b0, rdy_low}, 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: product must hold, new operands must be ignored.
        out_ready[0] = 1'b0;
        start_op(0, 16'h0003, 16'h0005, 32'h0000_000F, 1'b1);
        wait_valid(0, lat, rdy_low);
        for (int k = 0; k < 6; k++) begin
            in_valid[0] = 1'b1;
            in_a[0]     = 16'h7777;
            in_b[0]     = 16'h0100 + 16'(k);
            check("bp_out_valid", {31'b0, out_valid[0]}, 32'd1);
            check("bp_out_p",     out_p[0],              32'h0000_000F);
            check("bp_in_ready",  {31'b0, in_ready[0]},  32'd0);
            @(posedge clk);
            #1;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", {31'b0, out_valid[0]}, 32'd0);
        check("bp_release_in_ready",  {31'b0, in_ready[0]},  32'd1);
        check("out_p_holds_in_idle",  out_p[0],              32'h0000_000F);

        // Longer settle window on the second instance.
        start_op(1, 16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b1);
        wait_valid(1, lat, rdy_low);
        check("latency_s3", lat, 32'd13);
        @(posedge clk);
        #1;

        // Reset during pass 2 aborts the product.
        start_op(0, 16'h1234, 16'h1111, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pass2_core_xy", {16'b0, core_x[0], core_y[0]}, 32'h3411);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  {31'b0, in_ready[0]},  32'd1);
        check("abort_out_valid", {31'b0, out_valid[0]}, 32'd0);
        check("abort_out_p",     out_p[0],              32'd0);
        check("abort_core_xy",   {16'b0, core_x[0], core_y[0]}, 32'd0);
        check("abort_busy",      {31'b0, busy[0]},      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) saw_valid = 1'b1;
        end
        check("abort_no_out_valid", {31'b0, saw_valid}, 32'd0);

        start_op(0, 16'h0002, 16'h0003, 32'h0000_0006, 1'b1);
        wait_valid(0, lat, rdy_low);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
